pwm_regbank_mc: RTL and testbench
=================================

// Module: pwm_regbank_mc
// PURPOSE
//  Multi-channel PWM register bank with preload (shadow/active) registers. Sits between the
//  host register bus and the PWM core. Host writes land in shadow copies; the core-visible
//  active copies update either immediately or at the core's period-boundary update event.
//  Adds a sticky update-done status flag, an interrupt, and duty saturation against period.
// PARAMETERS
//  WIDTH   16  data/counter width (>=8)
//  NCH     4   number of PWM channels (1..16)
//  ADDR_W  6   word-address width (>=5)
// PORTS
//  clk            in   1          single clock, all logic on rising edge
//  rst_n          in   1          reset, synchronous, active-low
//  wr_en          in   1          write strobe, one word per cycle
//  rd_en          in   1          read strobe
//  addr           in   ADDR_W     word address
//  wr_data        in   WIDTH      write data
//  rd_data        out  WIDTH      read data, registered
//  rd_valid       out  1          rd_data valid, one cycle after rd_en
//  upd_evt        in   1          one-cycle pulse from core at period end
//  en             out  1          active global enable
//  mode           out  1          active mode (0 edge, 1 center-aligned)
//  ch_en          out  NCH        active per-channel enable mask
//  period         out  WIDTH      active period (ARR)
//  prescaler_div  out  WIDTH      active prescaler divisor
//  duty           out  NCH*WIDTH  active duty, channel i at [i*WIDTH +: WIDTH], saturated
//  irq            out  1          upd_done & IE, level
// BEHAVIOUR
//  Map (word addr): 0x00 CTRL {b4 IE, b3 FORCE_UPD(W, reads 0), b2 PE, b1 MODE, b0 EN};
//   0x01 STATUS {b1 PENDING(RO), b0 UPD_DONE(W1C)}; 0x02 PERIOD; 0x03 PRESC; 0x04 CH_EN;
//   0x10+i DUTY[i] for i<NCH. Other addresses: writes ignored, reads 0.
//  Reset (rst_n low at clk edge): all shadow, active, status, rd_data, rd_valid, irq = 0.
//  Reset mid-operation discards pending updates; no partial copy.
//  CTRL EN/MODE/IE/PE are not shadowed: take effect the cycle after the write.
//  PE=0: write to PERIOD/PRESC/CH_EN/DUTY updates shadow and active on the same edge.
//  PE=1: write updates shadow only and sets PENDING. On upd_evt (or FORCE_UPD, taking effect
//   one cycle after the CTRL write) with PENDING=1: all active <= shadow atomically,
//   PENDING <= 0, UPD_DONE <= 1. upd_evt with PENDING=0: no effect.
//  Write and upd_evt same cycle: active takes pre-write shadow; new value in shadow;
//   PENDING stays 1.
//  UPD_DONE set and W1C same cycle: set wins.
//  Clearing PE while PENDING=1: no copy occurs; PENDING stays until next event.
//  Duty output = min(duty_active, period_active), unsigned compare.
//  Reads: rd_data/rd_valid registered, latency 1. DUTY/PERIOD/PRESC/CH_EN read shadow.
//  Simultaneous rd_en and wr_en to same addr returns pre-write value.
// CONFIGURATION
//  PWM_WPROT_EN defined: CTRL b7 LOCK, set-only. Once 1, writes to CTRL,
//   PERIOD and PRESC are ignored until reset. DUTY, CH_EN and STATUS W1C remain writable.
//   LOCK reads back 1.
//  Undefined: b7 reads 0, writes ignored, no protection.
// STRUCTURE
//  Package pwm_pkg: address constants (PWM_A_CTRL, PWM_A_STATUS, PWM_A_PERIOD,
//   PWM_A_PRESC, PWM_A_CHEN, PWM_A_DUTY0), CTRL/STATUS bit index constants.
//  Sub-module pwm_shadow_reg #(W): one shadow+active pair with wr, pe, load inputs.
//   Instantiated for PERIOD, PRESC, CH_EN and NCH duties.
// TESTING
//  1. Reset, then read all mapped addrs -> rd_data 0 at 1-cycle latency; rd_valid pulses.
//  2. PE=0, write PERIOD=100 -> period=100 next cycle; STATUS.PENDING stays 0.
//  3. PE=1, write DUTY0=40, PERIOD=50 -> outputs unchanged, PENDING=1. Pulse upd_evt ->
//     duty[0]=40, period=50, UPD_DONE=1. Set IE=1 -> irq=1. Write STATUS=1 -> irq=0.
//  4. PE=1, PERIOD=50, write DUTY1=80, upd_evt -> duty[1] output 50 (saturated).
//  5. PE=1, write DUTY2=7 in same cycle as upd_evt -> active duty keeps old value.
//     PENDING=1 after; next upd_evt -> duty[2]=7.
//  6. With PWM_WPROT_EN: set LOCK, write PERIOD=9 -> period and readback unchanged.
//     DUTY writes still accepted. Reset clears LOCK.

Source files
------------

// File: rtl/pwm_pkg.sv
// +----------------------------------------------------------------------------+
// | pwm_pkg : register map and bit positions for the PWM register bank         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

  localparam int PWM_A_CTRL   = 'h00;
  localparam int PWM_A_STATUS = 'h01;
  localparam int PWM_A_PERIOD = 'h02;
  localparam int PWM_A_PRESC  = 'h03;
  localparam int PWM_A_CHEN   = 'h04;
  localparam int PWM_A_DUTY0  = 'h10;

  localparam int PWM_CTRL_EN    = 0;
  localparam int PWM_CTRL_MODE  = 1;
  localparam int PWM_CTRL_PE    = 2;
  localparam int PWM_CTRL_FORCE = 3;
  localparam int PWM_CTRL_IE    = 4;
  localparam int PWM_CTRL_LOCK  = 7;

  localparam int PWM_ST_DONE = 0;
  localparam int PWM_ST_PEND = 1;

endpackage

`default_nettype wire

// File: rtl/pwm_shadow_reg.sv
// +----------------------------------------------------------------------------+
// | pwm_shadow_reg : one shadow/active register pair with preload control      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_shadow_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         pe,
  input  logic         load,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr) shadow_d = wr_data;
    // A direct write is newer than anything a load could copy; load uses pre-write shadow.
    if (wr && !pe)  active_d = wr_data;
    else if (load)  active_d = shadow_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow = shadow_q;
  assign active = active_q;

endmodule

`default_nettype wire

// File: rtl/pwm_regbank_mc.sv
// +----------------------------------------------------------------------------+
// | pwm_regbank_mc : multi-channel PWM register bank with preload registers.   |
// | Optional write protection (CTRL.LOCK) when PWM_WPROT_EN is defined.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_regbank_mc
  import pwm_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 upd_evt,
  output logic                 en,
  output logic                 mode,
  output logic [NCH-1:0]       ch_en,
  output logic [WIDTH-1:0]     period,
  output logic [WIDTH-1:0]     prescaler_div,
  output logic [NCH*WIDTH-1:0] duty,
  output logic                 irq
);

  logic en_q, en_d, mode_q, mode_d, pe_q, pe_d, ie_q, ie_d;
  logic force_q, force_d, pending_q, pending_d, done_q, done_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             locked;

  logic sel_ctrl, sel_status, sel_period, sel_presc, sel_chen;
  logic ctrl_wr, wr_period, wr_presc, wr_chen, shadowed_wr, load;
  logic [NCH-1:0]   wr_duty;
  logic [WIDTH-1:0] period_sh, period_act, presc_sh, presc_act;
  logic [NCH-1:0]   chen_sh, chen_act;
  logic [WIDTH-1:0] duty_sh [NCH];
  logic [WIDTH-1:0] duty_act [NCH];
  logic [WIDTH-1:0] rd_val;

  assign sel_ctrl   = (addr == ADDR_W'(PWM_A_CTRL));
  assign sel_status = (addr == ADDR_W'(PWM_A_STATUS));
  assign sel_period = (addr == ADDR_W'(PWM_A_PERIOD));
  assign sel_presc  = (addr == ADDR_W'(PWM_A_PRESC));
  assign sel_chen   = (addr == ADDR_W'(PWM_A_CHEN));

  assign ctrl_wr     = wr_en && sel_ctrl && !locked;
  assign wr_period   = wr_en && sel_period && !locked;
  assign wr_presc    = wr_en && sel_presc && !locked;
  assign wr_chen     = wr_en && sel_chen;
  assign shadowed_wr = wr_period || wr_presc || wr_chen || (|wr_duty);
  assign load        = (upd_evt || force_q) && pending_q;

`ifdef PWM_WPROT_EN
  logic lock_q, lock_d;
  assign lock_d = lock_q || (ctrl_wr && wr_data[PWM_CTRL_LOCK]);
  always_ff @(posedge clk) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  pwm_shadow_reg #(.W(WIDTH)) u_period (
    .clk(clk), .rst_n(rst_n), .wr(wr_period), .pe(pe_q), .load(load),
    .wr_data(wr_data), .shadow(period_sh), .active(period_act));

  pwm_shadow_reg #(.W(WIDTH)) u_presc (
    .clk(clk), .rst_n(rst_n), .wr(wr_presc), .pe(pe_q), .load(load),
    .wr_data(wr_data), .shadow(presc_sh), .active(presc_act));

  pwm_shadow_reg #(.W(NCH)) u_chen (
    .clk(clk), .rst_n(rst_n), .wr(wr_chen), .pe(pe_q), .load(load),
    .wr_data(NCH'(wr_data)), .shadow(chen_sh), .active(chen_act));

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_duty
      assign wr_duty[i] = wr_en && (addr == ADDR_W'(PWM_A_DUTY0 + i));
      pwm_shadow_reg #(.W(WIDTH)) u_duty (
        .clk(clk), .rst_n(rst_n), .wr(wr_duty[i]), .pe(pe_q), .load(load),
        .wr_data(wr_data), .shadow(duty_sh[i]), .active(duty_act[i]));
      assign duty[i*WIDTH +: WIDTH] = (duty_act[i] > period_act) ? period_act : duty_act[i];
    end
  endgenerate

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    pe_d      = pe_q;
    ie_d      = ie_q;
    force_d   = 1'b0;
    pending_d = pending_q;
    done_d    = done_q;
    if (ctrl_wr) begin
      en_d    = wr_data[PWM_CTRL_EN];
      mode_d  = wr_data[PWM_CTRL_MODE];
      pe_d    = wr_data[PWM_CTRL_PE];
      ie_d    = wr_data[PWM_CTRL_IE];
      force_d = wr_data[PWM_CTRL_FORCE];
    end
    // A preloaded write racing an update keeps PENDING so the new value is not lost.
    if (shadowed_wr && pe_q) pending_d = 1'b1;
    else if (load)           pending_d = 1'b0;
    if (load)                                             done_d = 1'b1;
    else if (wr_en && sel_status && wr_data[PWM_ST_DONE]) done_d = 1'b0;
  end

  always_comb begin
    rd_val = '0;
    if (sel_ctrl)   rd_val = WIDTH'({locked, 2'b00, ie_q, 1'b0, pe_q, mode_q, en_q});
    if (sel_status) rd_val = WIDTH'({pending_q, done_q});
    if (sel_period) rd_val = period_sh;
    if (sel_presc)  rd_val = presc_sh;
    if (sel_chen)   rd_val = WIDTH'(chen_sh);
    for (int i = 0; i < NCH; i++) begin
      if (addr == ADDR_W'(PWM_A_DUTY0 + i)) rd_val = duty_sh[i];
    end
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      mode_q     <= 1'b0;
      pe_q       <= 1'b0;
      ie_q       <= 1'b0;
      force_q    <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      pe_q       <= pe_d;
      ie_q       <= ie_d;
      force_q    <= force_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign en            = en_q;
  assign mode          = mode_q;
  assign ch_en         = chen_act;
  assign period        = period_act;
  assign prescaler_div = presc_act;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign irq           = done_q && ie_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_regbank_mc.sv
// +----------------------------------------------------------------------------+
// | tb_pwm_regbank_mc : directed self-checking bench for pwm_regbank_mc        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pwm_regbank_mc;

  localparam int WIDTH  = 16;
  localparam int NCH    = 4;
  localparam int ADDR_W = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_en = 1'b0;
  logic                 rd_en = 1'b0;
  logic [ADDR_W-1:0]    addr = '0;
  logic [WIDTH-1:0]     wr_data = '0;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic                 upd_evt = 1'b0;
  logic                 en, mode, irq;
  logic [NCH-1:0]       ch_en;
  logic [WIDTH-1:0]     period, prescaler_div;
  logic [NCH*WIDTH-1:0] duty;

  int checks = 0;
  int failures = 0;

  pwm_regbank_mc #(.WIDTH(WIDTH), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .upd_evt(upd_evt),
    .en(en), .mode(mode), .ch_en(ch_en), .period(period),
    .prescaler_div(prescaler_div), .duty(duty), .irq(irq));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] duty_ch(input int i);
    return duty[i*WIDTH +: WIDTH];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; addr = ADDR_W'(a); wr_data = WIDTH'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    @(negedge clk);
    rd_en = 1'b1; addr = ADDR_W'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic evt();
    @(negedge clk);
    upd_evt = 1'b1;
    @(negedge clk);
    upd_evt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while rst_n is held low
    @(negedge clk); @(negedge clk);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_ctrl_outs", 32'({en, mode, ch_en, irq, rd_valid}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;

    // 1. All mapped addresses read zero with one-cycle latency
    rd("rd0_ctrl", 'h00, 0);
    rd("rd0_status", 'h01, 0);
    rd("rd0_period", 'h02, 0);
    rd("rd0_presc", 'h03, 0);
    rd("rd0_chen", 'h04, 0);
    for (int i = 0; i < NCH; i++) rd("rd0_duty", 'h10 + i, 0);
    @(negedge clk);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    wr('h05, 'h1234);
    rd("rd_unmapped", 'h05, 0);

    // 2. PE=0 immediate update
    wr('h00, 'h01);
    chk("en_set", 32'(en), 32'd1);
    wr('h02, 100);
    chk("period_direct", 32'(period), 32'd100);
    rd("status_no_pend", 'h01, 0);
    wr('h04, 'hF);
    chk("chen_direct", 32'(ch_en), 32'hF);

    // 3. Preload, update event, irq and W1C
    wr('h00, 'h05);
    wr('h10, 40);
    chk("duty0_held", 32'(duty_ch(0)), 32'd0);
    wr('h02, 50);
    chk("period_held", 32'(period), 32'd100);
    rd("status_pend", 'h01, 2);
    rd("period_shadow", 'h02, 50);
    evt();
    chk("period_loaded", 32'(period), 32'd50);
    chk("duty0_loaded", 32'(duty_ch(0)), 32'd40);
    rd("status_done", 'h01, 1);
    chk("irq_no_ie", 32'(irq), 32'd0);
    wr('h00, 'h15);
    chk("irq_set", 32'(irq), 32'd1);
    wr('h01, 1);
    chk("irq_cleared", 32'(irq), 32'd0);
    evt();
    rd("evt_no_pend", 'h01, 0);

    // 4. Saturation against period
    wr('h11, 80);
    evt();
    chk("duty1_sat", 32'(duty_ch(1)), 32'd50);
    rd("duty1_shadow", 'h11, 80);

    // 5. Write colliding with update event
    wr('h13, 20);
    @(negedge clk);
    wr_en = 1'b1; addr = ADDR_W'('h12); wr_data = WIDTH'(7); upd_evt = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; upd_evt = 1'b0;
    chk("duty2_old", 32'(duty_ch(2)), 32'd0);
    chk("duty3_loaded", 32'(duty_ch(3)), 32'd20);
    rd("status_pend_kept", 'h01, 3);
    evt();
    chk("duty2_loaded", 32'(duty_ch(2)), 32'd7);

    // FORCE_UPD copies one cycle after the CTRL write
    wr('h10, 30);
    wr('h00, 'h1D);
    chk("force_not_yet", 32'(duty_ch(0)), 32'd40);
    @(negedge clk);
    chk("force_loaded", 32'(duty_ch(0)), 32'd30);
    rd("ctrl_force_rd0", 'h00, 'h15);

    // Back to PE=0: duty write goes straight to active
    wr('h00, 'h11);
    wr('h10, 45);
    chk("duty0_direct", 32'(duty_ch(0)), 32'd45);

    // Reset mid-operation discards a pending update
    wr('h00, 'h05);
    wr('h02, 77);
    do_reset();
    evt();
    chk("rst_no_copy", 32'(period), 32'd0);
    rd("rst_status", 'h01, 0);

    // Same-cycle read and write of one address returns the old value
    wr('h02, 60);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = ADDR_W'('h02); wr_data = WIDTH'(70);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_old", 32'(rd_data), 32'd60);
    chk("rdwr_period", 32'(period), 32'd70);

`ifdef PWM_WPROT_EN
    // 6. Write protection
    wr('h00, 'h80);
    rd("lock_rd", 'h00, 'h80);
    wr('h02, 9);
    chk("lock_period", 32'(period), 32'd70);
    rd("lock_period_rd", 'h02, 70);
    wr('h10, 5);
    chk("lock_duty_ok", 32'(duty_ch(0)), 32'd5);
    wr('h00, 'h01);
    chk("lock_ctrl", 32'(en), 32'd0);
    do_reset();
    rd("lock_cleared", 'h00, 0);
`else
    wr('h00, 'h80);
    rd("nolock_rd", 'h00, 0);
    wr('h02, 9);
    chk("nolock_period", 32'(period), 32'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
